tag_match_mux: RTL and testbench
================================

TAG_MATCH_MUX -- requirements
Module: tag_match_mux

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways compared in parallel (power of two, >=2).
REQ-002 SHALL have parameter TAG_BITS, default 18, tag width.
REQ-003 SHALL have parameter LINE_BITS, default 512, cache line data width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-005 SHALL have parameter OFFSET_BITS, default 6, byte offset width; LINE_BITS = 8*2^OFFSET_BITS.
REQ-006 clk  input  1  clock; all registers update on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 i_valid  input  1  lookup request strobe for the current cycle.
REQ-009 i_tag  input  TAG_BITS  request tag.
REQ-010 i_offset  input  OFFSET_BITS  request byte offset within the line.
REQ-011 i_way_tags  input  WAYS*TAG_BITS  stored tags; way w at bits [w*TAG_BITS +: TAG_BITS].
REQ-012 i_way_valid  input  WAYS  stored valid bit per way.
REQ-013 i_way_data  input  WAYS*LINE_BITS  stored lines; way w at [w*LINE_BITS +: LINE_BITS].
REQ-014 o_hit_vec  output  WAYS  combinational per-way match (tag equal AND valid).
REQ-015 o_line  output  LINE_BITS  combinational selected line.
REQ-016 o_valid  output  1  registered: lookup result valid.
REQ-017 o_hit  output  1  registered hit flag.
REQ-018 o_miss  output  1  registered miss flag.
REQ-019 o_multi_hit  output  1  registered: more than one way matched.
REQ-020 o_hit_way  output  log2(WAYS)  registered index of selected way.
REQ-021 o_data  output  DATA_WIDTH  registered selected word.

Function
REQ-022 Per way SHALL compute eq[w] = (tag field of way w == i_tag), full-width equality, purely combinational.
REQ-023 SHALL compute o_hit_vec[w] = eq[w] AND i_way_valid[w]; an invalid way never matches, even when its tag equals.
REQ-024 Select: o_line SHALL equal the line of the lowest-index set bit of o_hit_vec; all zeros when o_hit_vec==0.
REQ-025 Word: word index = i_offset[OFFSET_BITS-1:2]; selected word = o_line[word_index*DATA_WIDTH +: DATA_WIDTH]; i_offset[1:0] ignored (no unaligned access, no wrap past line end).
REQ-026 On a rising edge with i_valid=1: o_valid<=1; o_hit<=|o_hit_vec; o_miss<=~|o_hit_vec; o_multi_hit<=(popcount(o_hit_vec)>1); o_hit_way<=lowest matching index (0 on miss); o_data<=selected word (0 on miss).
REQ-027 On a rising edge with i_valid=0: o_valid<=0, o_hit<=0, o_miss<=0; o_multi_hit, o_hit_way, o_data hold.
REQ-028 Latency: exactly one clock from sampled request to registered outputs; back-to-back requests every cycle supported, no stall.
REQ-029 o_hit and o_miss SHALL never both be 1; when o_valid=1 exactly one is 1.
REQ-030 Inputs not sampled when i_valid=0; no internal storage beyond the output registers.

Reset
REQ-031 While rst=1, all registered outputs SHALL be 0 immediately, independent of clk.
REQ-032 Combinational outputs o_hit_vec and o_line SHALL keep following inputs during reset.
REQ-033 Request sampled on the edge where rst deasserts SHALL NOT be taken; first lookup on the next edge.
REQ-034 Reset asserted mid-lookup SHALL discard the pending result; o_valid=0 after release until a new request.

Verification
REQ-035 Way 2 tag=0x155AA valid, others differ; i_tag=0x155AA, i_offset=8, way 2 word 2=0xDEADBEEF -> next cycle o_hit=1, o_hit_way=2, o_data=0xDEADBEEF, o_multi_hit=0.
REQ-036 Way 1 tag=i_tag but i_way_valid[1]=0, no other match -> o_hit_vec=0, o_miss=1, o_data=0, o_line=0.
REQ-037 Ways 1 and 3 both match and valid -> o_hit_way=1, o_multi_hit=1, o_data from way 1.
REQ-038 i_offset=63 on hit in way 0, word 15=0x12345678 -> o_data=0x12345678.
REQ-039 Requests on 3 consecutive cycles (hit, miss, hit) -> outputs follow one cycle later each; then i_valid=0 -> o_valid=0, o_data holds.
REQ-040 Assert rst between clock edges after a hit -> all registered outputs 0 at once; release, one request -> valid result one cycle later.

Source files
------------

// File: rtl/tag_match_mux_if.sv
// rtl/tag_match_mux_if.sv - lookup request, stored way contents and lookup result bundle
// master drives the request and way contents; slave is the tag_match_mux side.
interface tag_match_mux_if #(
  parameter int WAYS        = 4,
  parameter int TAG_BITS    = 18,
  parameter int LINE_BITS   = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int OFFSET_BITS = 6
);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                      i_valid;
  logic [TAG_BITS-1:0]       i_tag;
  logic [OFFSET_BITS-1:0]    i_offset;
  logic [WAYS*TAG_BITS-1:0]  i_way_tags;
  logic [WAYS-1:0]           i_way_valid;
  logic [WAYS*LINE_BITS-1:0] i_way_data;

  logic [WAYS-1:0]           o_hit_vec;
  logic [LINE_BITS-1:0]      o_line;
  logic                      o_valid;
  logic                      o_hit;
  logic                      o_miss;
  logic                      o_multi_hit;
  logic [WAY_BITS-1:0]       o_hit_way;
  logic [DATA_WIDTH-1:0]     o_data;

  modport master (
    output i_valid, i_tag, i_offset, i_way_tags, i_way_valid, i_way_data,
    input  o_hit_vec, o_line, o_valid, o_hit, o_miss, o_multi_hit, o_hit_way, o_data
  );

  modport slave (
    input  i_valid, i_tag, i_offset, i_way_tags, i_way_valid, i_way_data,
    output o_hit_vec, o_line, o_valid, o_hit, o_miss, o_multi_hit, o_hit_way, o_data
  );
endinterface

// File: rtl/tag_match_mux.sv
// rtl/tag_match_mux.sv - parallel tag compare, lowest-way line select and word extract
// Hit vector and line are combinational; lookup result is registered one clock later.
module tag_match_mux #(
  parameter int WAYS        = 4,
  parameter int TAG_BITS    = 18,
  parameter int LINE_BITS   = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int OFFSET_BITS = 6
) (
  input  logic           clk,
  input  logic           rst,
  tag_match_mux_if.slave bus
);
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int WORDS     = LINE_BITS / DATA_WIDTH;
  localparam int WIDX_BITS = OFFSET_BITS - 2;

  logic [WAYS-1:0]       hit_vec;
  logic [WAY_BITS-1:0]   sel_way;
  logic [LINE_BITS-1:0]  sel_line;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [WIDX_BITS-1:0]  word_idx;
  logic                  any_hit;
  logic                  multi_hit;
  logic [1:0]            unused_offset;

  logic                  valid_q, valid_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;
  logic                  multi_q, multi_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Byte lane within a word is irrelevant: only aligned words are returned.
  assign unused_offset = bus.i_offset[1:0];
  assign word_idx      = bus.i_offset[OFFSET_BITS-1:2];

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = bus.i_way_valid[w] &&
                   (bus.i_way_tags[w*TAG_BITS +: TAG_BITS] == bus.i_tag);
    end
  end

  // Descending scan so the lowest matching way is the last one written.
  always_comb begin
    sel_way  = '0;
    sel_line = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        sel_way  = WAY_BITS'(w);
        sel_line = bus.i_way_data[w*LINE_BITS +: LINE_BITS];
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (int'(word_idx) == k) begin
        sel_word = sel_line[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more ways hit.
  assign any_hit   = |hit_vec;
  assign multi_hit = |(hit_vec & (hit_vec - WAYS'(1)));

  always_comb begin
    valid_d = bus.i_valid;
    hit_d   = bus.i_valid & any_hit;
    miss_d  = bus.i_valid & ~any_hit;
    multi_d = multi_q;
    way_d   = way_q;
    data_d  = data_q;
    if (bus.i_valid) begin
      multi_d = multi_hit;
      way_d   = sel_way;
      data_d  = sel_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      multi_q <= 1'b0;
      way_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      multi_q <= multi_d;
      way_q   <= way_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_hit_vec   = hit_vec;
  assign bus.o_line      = sel_line;
  assign bus.o_valid     = valid_q;
  assign bus.o_hit       = hit_q;
  assign bus.o_miss      = miss_q;
  assign bus.o_multi_hit = multi_q;
  assign bus.o_hit_way   = way_q;
  assign bus.o_data      = data_q;
endmodule

// File: tb/tb_tag_match_mux.sv
// tb/tb_tag_match_mux.sv - directed and randomized lookups against a word-array reference model
module tb_tag_match_mux;
  localparam int W  = 4;
  localparam int TB = 18;
  localparam int LB = 512;
  localparam int DW = 32;
  localparam int OB = 6;

  logic clk;
  logic rst;

  tag_match_mux_if #(.WAYS(W), .TAG_BITS(TB), .LINE_BITS(LB), .DATA_WIDTH(DW), .OFFSET_BITS(OB)) bus ();

  tag_match_mux #(.WAYS(W), .TAG_BITS(TB), .LINE_BITS(LB), .DATA_WIDTH(DW), .OFFSET_BITS(OB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [TB-1:0] m_tag [W];
  logic          m_vld [W];
  logic [DW-1:0] m_word [W][16];
  logic [TB-1:0] pool [4];

  logic          e_valid, e_hit, e_miss, e_multi;
  logic [1:0]    e_way;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "/o_valid"},     LB'(bus.o_valid),     LB'(e_valid));
    chk({tag, "/o_hit"},       LB'(bus.o_hit),       LB'(e_hit));
    chk({tag, "/o_miss"},      LB'(bus.o_miss),      LB'(e_miss));
    chk({tag, "/o_multi_hit"}, LB'(bus.o_multi_hit), LB'(e_multi));
    chk({tag, "/o_hit_way"},   LB'(bus.o_hit_way),   LB'(e_way));
    chk({tag, "/o_data"},      LB'(bus.o_data),      LB'(e_data));
  endtask

  task automatic clear_expect();
    e_valid = 0; e_hit = 0; e_miss = 0; e_multi = 0; e_way = 0; e_data = 0;
  endtask

  task automatic rand_cfg();
    for (int w = 0; w < W; w++) begin
      m_tag[w] = pool[$urandom_range(0, 3)];
      m_vld[w] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) m_word[w][k] = $urandom;
    end
  endtask

  task automatic drive(input logic v, input logic [TB-1:0] tag, input logic [OB-1:0] off);
    bus.i_valid  = v;
    bus.i_tag    = tag;
    bus.i_offset = off;
    for (int w = 0; w < W; w++) begin
      bus.i_way_tags[w*TB +: TB] = m_tag[w];
      bus.i_way_valid[w]         = m_vld[w];
      for (int k = 0; k < 16; k++) bus.i_way_data[w*LB + k*DW +: DW] = m_word[w][k];
    end
  endtask

  // Reference: match = valid and equal tag; pick first matching way; word = offset/4.
  task automatic model_comb(input logic [TB-1:0] tag, input logic [OB-1:0] off,
                            output logic [W-1:0] hv, output logic [LB-1:0] line,
                            output int first, output logic [DW-1:0] word);
    hv = '0; line = '0; word = '0; first = -1;
    for (int w = 0; w < W; w++) hv[w] = m_vld[w] && (m_tag[w] == tag);
    for (int w = 0; w < W; w++) if (hv[w] && first < 0) first = w;
    if (first >= 0) begin
      for (int k = 0; k < 16; k++) line[k*DW +: DW] = m_word[first][k];
      word = m_word[first][off >> 2];
    end
  endtask

  task automatic step(input logic v, input logic [TB-1:0] tag, input logic [OB-1:0] off, input string name);
    logic [W-1:0]  hv;
    logic [LB-1:0] line;
    logic [DW-1:0] word;
    int            first;
    int            n;
    drive(v, tag, off);
    #1;
    model_comb(tag, off, hv, line, first, word);
    chk({name, "/o_hit_vec"}, LB'(bus.o_hit_vec), LB'(hv));
    chk({name, "/o_line"}, bus.o_line, line);
    if (v) begin
      n = 0;
      for (int w = 0; w < W; w++) n += int'(hv[w]);
      e_valid = 1;
      e_hit   = (first >= 0);
      e_miss  = (first < 0);
      e_multi = (n > 1);
      e_way   = (first < 0) ? 2'd0 : first[1:0];
      e_data  = word;
    end else begin
      e_valid = 0; e_hit = 0; e_miss = 0;
    end
    @(posedge clk);
    #1;
    chk_regs(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  hv;
    logic [LB-1:0] line;
    logic [DW-1:0] word;
    int            first;

    pool[0] = 18'h155AA; pool[1] = 18'h00001; pool[2] = 18'h3FFFF; pool[3] = 18'h20000;

    // Reset: registered outputs zero, combinational path live, request held off.
    rst = 1'b1;
    rand_cfg();
    m_tag[0] = 18'h00001; m_tag[1] = 18'h00002; m_tag[2] = 18'h155AA; m_tag[3] = 18'h00003;
    for (int w = 0; w < W; w++) m_vld[w] = 1'b1;
    m_word[2][2] = 32'hDEADBEEF;
    drive(1'b1, 18'h155AA, 6'd8);
    #2;
    clear_expect();
    model_comb(18'h155AA, 6'd8, hv, line, first, word);
    chk("reset/o_hit_vec", LB'(bus.o_hit_vec), LB'(hv));
    chk("reset/o_line", bus.o_line, line);
    chk_regs("reset");
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset_held");
    rst = 1'b0;
    #1;
    chk_regs("reset_release");

    step(1'b1, 18'h155AA, 6'd8, "way2_hit");
    chk("way2_hit/const_data", LB'(bus.o_data), LB'(32'hDEADBEEF));
    chk("way2_hit/const_way", LB'(bus.o_hit_way), LB'(2'd2));

    m_tag[1] = 18'h0ABCD; m_vld[1] = 1'b0;
    step(1'b1, 18'h0ABCD, 6'd20, "invalid_way");
    chk("invalid_way/const_miss", LB'(bus.o_miss), LB'(1'b1));

    m_tag[1] = 18'h2AAAA; m_tag[3] = 18'h2AAAA; m_vld[1] = 1'b1; m_vld[3] = 1'b1;
    step(1'b1, 18'h2AAAA, 6'd13, "multi_hit");
    chk("multi_hit/const_way", LB'(bus.o_hit_way), LB'(2'd1));

    m_tag[0] = 18'h3FFFF; m_vld[0] = 1'b1; m_word[0][15] = 32'h12345678;
    step(1'b1, 18'h3FFFF, 6'd63, "last_word");
    chk("last_word/const_data", LB'(bus.o_data), LB'(32'h12345678));

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) rand_cfg();
      step(1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)], 6'($urandom), "random");
    end

    // Back-to-back hit, miss, hit, then idle.
    rand_cfg();
    m_tag[3] = 18'h155AA; m_vld[3] = 1'b1;
    m_tag[0] = 18'h00001; m_tag[1] = 18'h00001; m_tag[2] = 18'h00001;
    step(1'b1, 18'h155AA, 6'd4, "b2b_hit1");
    step(1'b1, 18'h20000, 6'd4, "b2b_miss");
    step(1'b1, 18'h155AA, 6'd44, "b2b_hit2");
    step(1'b0, 18'h155AA, 6'd0, "b2b_idle");

    // Reset between edges while a request is pending.
    step(1'b1, 18'h155AA, 6'd28, "pre_reset_hit");
    drive(1'b1, 18'h155AA, 6'd32);
    #2;
    rst = 1'b1;
    #1;
    clear_expect();
    chk_regs("mid_reset");
    @(posedge clk);
    #1;
    chk_regs("mid_reset_edge");
    rst = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    chk_regs("after_release");
    step(1'b1, 18'h155AA, 6'd36, "post_reset_hit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
